// File: rtl/mult_pipe_unit.sv
// Pipelined integer / carry-less multiply unit with ready/valid backpressure and flush.
// All arithmetic is done ahead of stage 1; the stages only carry result, tag and valid.
module mult_pipe_unit #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned PIPE_STAGES   = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter bit          CLMUL_EN      = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [2:0]               op_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4,
    OP_CLMUL  = 3'd5,
    OP_CLMULH = 3'd6,
    OP_CLMULR = 3'd7
  } mult_op_e;

  logic                     adv;
  logic                     a_signed;
  logic                     b_signed;
  logic [2*XLEN-1:0]        a_wide;
  logic [2*XLEN-1:0]        b_wide;
  logic [2*XLEN-1:0]        prod;
  logic [XLEN-1:0]          mulw_res;
  logic [2*XLEN-1:0]        clmul_prod;
  logic [XLEN-1:0]          result_d;

  logic [PIPE_STAGES-1:0]   valid_q;
  logic [XLEN-1:0]          res_q [PIPE_STAGES];
  logic [TRANS_ID_BITS-1:0] tag_q [PIPE_STAGES];

  assign adv     = !valid_o || ready_i;
  assign ready_o = adv;

  assign a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU);
  assign b_signed = (op_i == OP_MULH);

  // Extending both operands to 2*XLEN makes a truncated unsigned multiply
  // produce the correct signed, mixed or unsigned double-width product.
  assign a_wide = {{XLEN{a_signed & operand_a_i[XLEN-1]}}, operand_a_i};
  assign b_wide = {{XLEN{b_signed & operand_b_i[XLEN-1]}}, operand_b_i};
  assign prod   = a_wide * b_wide;

  assign mulw_res = XLEN'($signed(prod[31:0]));

  generate
    if (CLMUL_EN) begin : g_clmul
      always_comb begin
        clmul_prod = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
          if (operand_b_i[i]) begin
            clmul_prod = clmul_prod ^ ({{XLEN{1'b0}}, operand_a_i} << i);
          end
        end
      end
    end else begin : g_no_clmul
      assign clmul_prod = '0;
    end
  endgenerate

  always_comb begin
    result_d = '0;
    case (op_i)
      OP_MUL:    result_d = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  result_d = prod[2*XLEN-1:XLEN];
      OP_MULW:   result_d = mulw_res;
      OP_CLMUL:  result_d = clmul_prod[XLEN-1:0];
      OP_CLMULH: result_d = clmul_prod[2*XLEN-1:XLEN];
      OP_CLMULR: result_d = clmul_prod[2*XLEN-2:XLEN-1];
      default:   result_d = '0;
    endcase
  end

  // Flush wins over stall so in-flight ops die even while writeback is blocked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q[0] <= valid_i;
      for (int k = 1; k < int'(PIPE_STAGES); k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(PIPE_STAGES); k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else if (adv) begin
      res_q[0] <= result_d;
      tag_q[0] <= trans_id_i;
      for (int k = 1; k < int'(PIPE_STAGES); k++) begin
        res_q[k] <= res_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign valid_o    = valid_q[PIPE_STAGES-1];
  assign result_o   = res_q[PIPE_STAGES-1];
  assign trans_id_o = tag_q[PIPE_STAGES-1];

endmodule

// File: doc/mult_pipe_unit.md
Name: mult_pipe_unit

Overview:
Parametrised, fully pipelined integer and carry-less multiply functional unit for the execute stage. It is generalised in XLEN and pipeline depth, and adds downstream backpressure (ready/valid) and flush, which the single-stage unit lacks. Throughput is one operation per cycle. Results leave in issue order after PIPE_STAGES cycles when there is no stall.

Parameters:
XLEN, 64, operand/result width; legal values 32 or 64.
PIPE_STAGES, 2, number of register stages between the input and result_o; must be ≥1; the synthesiser retimes the multiplier across them.
TRANS_ID_BITS, 3, width of the scoreboard transaction tag.
CLMUL_EN, 1, 1 = carry-less ops implemented; 0 = carry-less ops return 0.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  kill all in-flight operations
valid_i  in  1  operation presented
ready_o  out  1  unit accepts the operation this cycle
op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5 CLMUL, 6 CLMULH, 7 CLMULR
operand_a_i  in  XLEN  rs1
operand_b_i  in  XLEN  rs2
trans_id_i  in  TRANS_ID_BITS  tag, travels with the op
valid_o  out  1  result available
ready_i  in  1  writeback accepts the result
result_o  out  XLEN  result
trans_id_o  out  TRANS_ID_BITS  tag of result_o

Behaviour:
- Reset: rst_ni asynchronous, active-low; clock clk_i. All stage valid bits, result_o and trans_id_o go to 0, so valid_o=0. Reset asserted mid-operation discards every in-flight op; none emerges after release.
- Pipeline control:
  - Global enable adv = !valid_o | ready_i. All stages shift together when adv=1 and all hold when adv=0.
  - ready_o = adv.
  - Accept happens when valid_i & ready_o; the stage-1 valid bit loads valid_i & adv.
  - Bubbles are not collapsed.
- Latency: an op accepted in cycle N appears with valid_o=1 in cycle N+PIPE_STAGES if no stall occurs; each stall cycle adds one cycle.
- Output hold: while valid_o=1 and ready_i=0, result_o, trans_id_o and valid_o are held stable.
- Flush:
  - flush_i=1 synchronously clears all stage valid bits, including the output stage, at the next edge.
  - An op presented with valid_i in the same cycle as flush_i is dropped.
  - Data and tag registers need not be cleared.
  - flush_i overrides stall.
- Arithmetic: compute all ops at the input (combinationally, before stage 1), then pipeline the result.
  - MUL: low XLEN bits of a*b.
  - MULH: high XLEN bits of signed×signed, using XLEN+1-bit sign-extended operands, 2·XLEN-bit product.
  - MULHSU: high XLEN bits of signed a × unsigned b.
  - MULHU: high XLEN bits of unsigned×unsigned.
  - MULW (XLEN=64): product of a[31:0]*b[31:0], take bits [31:0], sign-extend to 64. With XLEN=32, MULW behaves as MUL.
  - Carry-less product P (2·XLEN-1 bits): P = XOR over i of (b[i] ? a<<i : 0).
    - CLMUL = P[XLEN-1:0].
    - CLMULH = P[2·XLEN-1:XLEN] (top bit 0).
    - CLMULR = P[2·XLEN-2:XLEN-1].
  - CLMUL_EN=0: ops 5–7 are still accepted and tagged, and complete with result 0.
- Ordering: results emerge strictly in acceptance order, and each trans_id stays paired with its own result.
- No error outputs. Every op_i encoding is legal.

Test Plan:
- Basic latency (XLEN=64, PIPE_STAGES=2): MUL a=3, b=5, tag 5 accepted at cycle 0, ready_i=1 → valid_o=1 at cycle 2 with result 15, trans_id 5; valid_o=0 at cycles 0–1.
- High products:
  - MULH a=b=0xFFFF_FFFF_FFFF_FFFF → 0.
  - MULHU same operands → 0xFFFF_FFFF_FFFF_FFFE.
  - MULHSU a=0xFFFF_FFFF_FFFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
  - MULW a=0x7FFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFE.
- Carry-less:
  - CLMUL 3·3 → 5.
  - CLMULH a=b=1<<63 → 1<<62.
  - CLMULR a=b=1<<63 → 1<<63.
  - With CLMUL_EN=0, CLMUL 3·3 → 0 with valid_o=1.
- Backpressure: issue back-to-back ops with tags 1,2,3. Hold ready_i=0 for 3 cycles once tag 1 reaches the output → ready_o=0, and tag 1 and its result stay stable. After ready_i=1, tags 1,2,3 appear on consecutive cycles, with no loss or duplication.
- Flush: with 2 ops in flight plus valid_i=1, assert flush_i for one cycle → valid_o stays 0 for the following PIPE_STAGES+1 cycles. A new op issued afterwards completes normally.
- Reset mid-operation: drop rst_ni with the pipe full → valid_o, result_o and trans_id_o are 0 immediately (asynchronously). After release, no stale result appears.
